// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with a registered one-hot grant and a binary grant index.
// Latency: 1 cycle from req to gnt; bin is derived combinationally from the gnt register.
// Backpressure: the grant holds while rdy is low; completion re-arbitrates with no bubble.
// Optional macro ARB_RR_OHT_LOCK_EN: when defined, the grant holds until rdy & lst (multi-beat lock).

// One-hot to binary encoder; scans SPLIT groups and ORs in the index of the set bit.
module oht2bin #(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    parameter int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     oht,
    output logic [WIDTH_LOG-1:0] bin
);
    localparam int GW = (WIDTH + SPLIT - 1) / SPLIT;

    // OR together the indices of all set bits; exact for one-hot, 0 when idle
    always_comb begin
        int idx;
        bin = '0;
        idx = 0;
        if (IMPLEMENTATION == 0) begin
            for (int g = 0; g < SPLIT; g++) begin
                for (int k = 0; k < GW; k++) begin
                    idx = g * GW + k;
                    if (idx < WIDTH) begin
                        if (oht[idx]) bin = bin | idx[WIDTH_LOG-1:0];
                    end
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                idx = i;
                if (oht[i]) bin = bin | idx[WIDTH_LOG-1:0];
            end
        end
    end
endmodule

module arb_rr_oht #(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    input  logic                 lst,
    input  logic                 rdy,
    output logic [WIDTH-1:0]     gnt,
    output logic [WIDTH_LOG-1:0] bin,
    output logic                 vld
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [WIDTH_LOG-1:0] ptr;
    logic [WIDTH_LOG-1:0] nxt_ptr;
    logic [WIDTH_LOG-1:0] base;
    logic [WIDTH-1:0]     win;
    logic                 done;

    oht2bin #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION),
        .WIDTH_LOG      (WIDTH_LOG)
    ) u_oht2bin (
        .oht (gnt),
        .bin (bin)
    );

`ifdef ARB_RR_OHT_LOCK_EN
    assign done = rdy & lst;
`else
    // Every accepted beat re-arbitrates; lst is intentionally unused here
    logic unused_lst;
    assign unused_lst = lst;
    assign done = rdy;
`endif

    // Pointer after the current owner, wrapping modulo WIDTH rather than 2^WIDTH_LOG
    assign nxt_ptr = (bin == WIDTH_LOG'(WIDTH - 1)) ? '0 : bin + 1'b1;

    // Circular priority search from base; in BUSY it already uses the post-completion pointer
    always_comb begin
        int                   j;
        logic [WIDTH_LOG-1:0] jj;
        logic                 found;
        base  = (state == BUSY) ? nxt_ptr : ptr;
        win   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            j = int'(base) + i;
            if (j >= WIDTH) j = j - WIDTH;
            jj = j[WIDTH_LOG-1:0];
            if (!found && req[jj]) begin
                win[jj] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    // Grant FSM: IDLE takes any request; BUSY holds until completion, then hands over without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            vld   <= 1'b0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= win;
                        vld   <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        ptr   <= nxt_ptr;
                        gnt   <= win;
                        vld   <= |req;
                        state <= (|req) ? BUSY : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    vld   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arb_rr_oht.sv
// Directed bench for arb_rr_oht with WIDTH=4 and WIDTH=5 instances.
// Expected values are hand-computed; lock/no-lock expectations follow ARB_RR_OHT_LOCK_EN.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_arb_rr_oht;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req4 = '0;
    logic       lst4 = 1'b0, rdy4 = 1'b0;
    logic [3:0] gnt4;
    logic [1:0] bin4;
    logic       vld4;
    logic [4:0] req5 = '0;
    logic       lst5 = 1'b0, rdy5 = 1'b0;
    logic [4:0] gnt5;
    logic [2:0] bin5;
    logic       vld5;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    arb_rr_oht #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .lst(lst4), .rdy(rdy4),
        .gnt(gnt4), .bin(bin4), .vld(vld4)
    );

    arb_rr_oht #(.WIDTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .lst(lst5), .rdy(rdy5),
        .gnt(gnt5), .bin(bin5), .vld(vld5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with all requests pending
        req4 = 4'b1111;
        step();
        step();
        chk("rst_gnt", 32'(gnt4), 32'h0);
        chk("rst_bin", 32'(bin4), 32'h0);
        chk("rst_vld", 32'(vld4), 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_gnt", 32'(gnt4), 32'h1);
        chk("post_rst_bin", 32'(bin4), 32'h0);
        chk("post_rst_vld", 32'(vld4), 32'h1);

        // Rotation with single-beat transfers
        rdy4 = 1'b1;
        lst4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("rot_bin%0d", k), 32'(bin4), 32'((k + 1) % 4));
            chk($sformatf("rot_vld%0d", k), 32'(vld4), 32'h1);
        end
        chk("rot_end_gnt", 32'(gnt4), 32'h4);

        // Owner is index 2; beats with lst=0 under req=1011
        req4 = 4'b1011;
        lst4 = 1'b0;
`ifdef ARB_RR_OHT_LOCK_EN
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("lock_hold%0d", k), 32'(gnt4), 32'h4);
        end
        lst4 = 1'b1;
        step();
        chk("lock_release", 32'(gnt4), 32'h8);
`else
        step();
        chk("nolock_a", 32'(gnt4), 32'h8);
        step();
        chk("nolock_b", 32'(gnt4), 32'h1);
        step();
        chk("nolock_c", 32'(gnt4), 32'h2);
        lst4 = 1'b1;
        step();
        chk("nolock_d", 32'(gnt4), 32'h8);
`endif

        // Completion with no requests returns to IDLE; rdy/lst ignored there
        req4 = 4'b0000;
        step();
        chk("idle_vld", 32'(vld4), 32'h0);
        chk("idle_gnt", 32'(gnt4), 32'h0);
        step();
        chk("idle_stay", 32'(vld4), 32'h0);

        // Last served was 3, so ptr=0; grant held while rdy low
        req4 = 4'b0011;
        rdy4 = 1'b0;
        step();
        chk("regrant_gnt", 32'(gnt4), 32'h1);
        step();
        step();
        chk("hold_rdy0", 32'(gnt4), 32'h1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt4), 32'h0);
        chk("async_vld", 32'(vld4), 32'h0);
        chk("async_bin", 32'(bin4), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("restart_gnt", 32'(gnt4), 32'h1);

        // rdy=1, lst=0 with two requesters
        rdy4 = 1'b1;
        lst4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef ARB_RR_OHT_LOCK_EN
            chk($sformatf("beats_bin%0d", k), 32'(bin4), 32'h0);
`else
            chk($sformatf("alt_bin%0d", k), 32'(bin4), 32'((k + 1) % 2));
`endif
        end
        req4 = 4'b0000;
        rdy4 = 1'b0;

        // WIDTH=5 wrap: serve 3 so ptr becomes 4, then req=00011
        req5 = 5'b01000;
        rdy5 = 1'b0;
        step();
        chk("w5_first", 32'(bin5), 32'h3);
        req5 = 5'b00011;
        rdy5 = 1'b1;
        lst5 = 1'b1;
        step();
        chk("w5_wrap_bin", 32'(bin5), 32'h0);
        chk("w5_wrap_gnt", 32'(gnt5), 32'h01);
        step();
        chk("w5_next_bin", 32'(bin5), 32'h1);
        req5 = 5'b10001;
        step();
        chk("w5_top_bin", 32'(bin5), 32'h4);
        step();
        chk("w5_mod5_bin", 32'(bin5), 32'h0);
        req5 = 5'b00000;
        step();
        chk("w5_idle_vld", 32'(vld5), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
